// File: rtl/leaf_pkg.sv
// Shared definitions for the leaf stream buffer: default payload width and
// the width helpers every file in the slice derives its bus sizes from.
package leaf_pkg;

    localparam int LEAF_PAYLOAD_BITS = 32;

    // Smallest r with 2**r >= n.
    function automatic int leaf_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Occupancy must be able to represent DEPTH itself, hence DEPTH+1 states.
    function automatic int leaf_cnt_bits(input int depth);
        return leaf_clog2(depth + 1);
    endfunction

    function automatic int leaf_slice_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/leaf_stream_buffer_if.sv
// Stream bundle between leaf_interface/kernel (master) and the elastic buffer (slave).
interface leaf_stream_buffer_if
    import leaf_pkg::*;
#(
    parameter int PAYLOAD_BITS  = LEAF_PAYLOAD_BITS,
    parameter int NUM_IN_PORTS  = 2,
    parameter int NUM_OUT_PORTS = 2,
    parameter int DEPTH         = 4
);
    localparam int CNT_BITS = leaf_cnt_bits(DEPTH);
    localparam int NUM_CH   = NUM_IN_PORTS + NUM_OUT_PORTS;

    logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_leaf_interface2user;
    logic [NUM_IN_PORTS-1:0]               vld_interface2user;
    logic [NUM_IN_PORTS-1:0]               ack_user2interface;
    logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  user_in_data;
    logic [NUM_IN_PORTS-1:0]               user_in_vld;
    logic [NUM_IN_PORTS-1:0]               user_in_ack;
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] user_out_data;
    logic [NUM_OUT_PORTS-1:0]              user_out_vld;
    logic [NUM_OUT_PORTS-1:0]              user_out_ack;
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
    logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
    logic [NUM_OUT_PORTS-1:0]              ack_interface2user;
    logic [NUM_CH*CNT_BITS-1:0]            occupancy;
    logic [NUM_CH*CNT_BITS-1:0]            high_water;

    modport master (
        output dout_leaf_interface2user, vld_interface2user,
        input  ack_user2interface,
        input  user_in_data, user_in_vld,
        output user_in_ack,
        output user_out_data, user_out_vld,
        input  user_out_ack,
        input  din_leaf_user2interface, vld_user2interface,
        output ack_interface2user,
        input  occupancy, high_water
    );

    modport slave (
        input  dout_leaf_interface2user, vld_interface2user,
        output ack_user2interface,
        output user_in_data, user_in_vld,
        input  user_in_ack,
        input  user_out_data, user_out_vld,
        output user_out_ack,
        output din_leaf_user2interface, vld_user2interface,
        input  ack_interface2user,
        output occupancy, high_water
    );

endinterface

// File: rtl/leaf_stream_fifo.sv
// One channel FIFO: count-driven full/empty flags, live occupancy and a
// high-water mark, both cleared by async reset or synchronous flush.
module leaf_stream_fifo
    import leaf_pkg::*;
#(
    parameter  int PAYLOAD_BITS = LEAF_PAYLOAD_BITS,
    parameter  int DEPTH        = 4,
    localparam int CNT_BITS     = leaf_cnt_bits(DEPTH),
    localparam int PTR_BITS     = leaf_clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [PAYLOAD_BITS-1:0] push_data,
    input  logic                    push_vld,
    output logic                    push_ack,
    output logic [PAYLOAD_BITS-1:0] pop_data,
    output logic                    pop_vld,
    input  logic                    pop_ack,
    output logic [CNT_BITS-1:0]     count,
    output logic [CNT_BITS-1:0]     high_water
);

    logic [PAYLOAD_BITS-1:0] mem [DEPTH];
    logic [PTR_BITS-1:0]     wr_ptr_reg;
    logic [PTR_BITS-1:0]     rd_ptr_reg;
    logic [CNT_BITS-1:0]     count_reg;
    logic [CNT_BITS-1:0]     count_next;
    logic [CNT_BITS-1:0]     hwm_reg;
    logic                    full_reg;
    logic                    empty_reg;
    logic                    push_fire;
    logic                    pop_fire;

    // Handshakes only look at registered flags, so vld never feeds ack combinationally.
    assign push_fire = push_vld & ~full_reg;
    assign pop_fire  = pop_ack & ~empty_reg;

    always_comb begin
        count_next = count_reg;
        if (push_fire && !pop_fire) begin
            count_next = count_reg + CNT_BITS'(1);
        end else if (!push_fire && pop_fire) begin
            count_next = count_reg - CNT_BITS'(1);
        end
    end

    // Storage is deliberately left out of reset; the head word is read
    // asynchronously so it is visible the cycle after it was written.
    always_ff @(posedge clk) begin
        if (push_fire && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            hwm_reg    <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            hwm_reg    <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (push_fire) wr_ptr_reg <= wr_ptr_reg + PTR_BITS'(1);
            if (pop_fire)  rd_ptr_reg <= rd_ptr_reg + PTR_BITS'(1);
            count_reg <= count_next;
            full_reg  <= (count_next == CNT_BITS'(DEPTH));
            empty_reg <= (count_next == '0);
            if (count_next > hwm_reg) hwm_reg <= count_next;
        end
    end

    assign push_ack   = ~full_reg;
    assign pop_vld    = ~empty_reg;
    assign pop_data   = mem[rd_ptr_reg];
    assign count      = count_reg;
    assign high_water = hwm_reg;

endmodule

// File: rtl/leaf_stream_buffer.sv
// Multi-channel elastic buffer between leaf_interface and an HLS kernel:
// one FIFO per stream; this level only slices and packs the channel buses.
module leaf_stream_buffer
    import leaf_pkg::*;
#(
    parameter int PAYLOAD_BITS  = LEAF_PAYLOAD_BITS,
    parameter int NUM_IN_PORTS  = 2,
    parameter int NUM_OUT_PORTS = 2,
    parameter int DEPTH         = 4
) (
    input  logic                 clk_user,
    input  logic                 reset_n,
    input  logic                 flush,
    leaf_stream_buffer_if.slave  bus
);

    localparam int PB       = PAYLOAD_BITS;
    localparam int CNT_BITS = leaf_cnt_bits(DEPTH);

    // Interface->user channels occupy status slots 0..NUM_IN_PORTS-1.
    for (genvar gi = 0; gi < NUM_IN_PORTS; gi++) begin : g_in
        leaf_stream_fifo #(
            .PAYLOAD_BITS (PB),
            .DEPTH        (DEPTH)
        ) u_fifo (
            .clk        (clk_user),
            .rst_n      (reset_n),
            .flush      (flush),
            .push_data  (bus.dout_leaf_interface2user[leaf_slice_lsb(gi, PB) +: PB]),
            .push_vld   (bus.vld_interface2user[gi]),
            .push_ack   (bus.ack_user2interface[gi]),
            .pop_data   (bus.user_in_data[leaf_slice_lsb(gi, PB) +: PB]),
            .pop_vld    (bus.user_in_vld[gi]),
            .pop_ack    (bus.user_in_ack[gi]),
            .count      (bus.occupancy[leaf_slice_lsb(gi, CNT_BITS) +: CNT_BITS]),
            .high_water (bus.high_water[leaf_slice_lsb(gi, CNT_BITS) +: CNT_BITS])
        );
    end

    // User->interface channels follow in the status vectors.
    for (genvar gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_out
        leaf_stream_fifo #(
            .PAYLOAD_BITS (PB),
            .DEPTH        (DEPTH)
        ) u_fifo (
            .clk        (clk_user),
            .rst_n      (reset_n),
            .flush      (flush),
            .push_data  (bus.user_out_data[leaf_slice_lsb(gi, PB) +: PB]),
            .push_vld   (bus.user_out_vld[gi]),
            .push_ack   (bus.user_out_ack[gi]),
            .pop_data   (bus.din_leaf_user2interface[leaf_slice_lsb(gi, PB) +: PB]),
            .pop_vld    (bus.vld_user2interface[gi]),
            .pop_ack    (bus.ack_interface2user[gi]),
            .count      (bus.occupancy[leaf_slice_lsb(NUM_IN_PORTS + gi, CNT_BITS) +: CNT_BITS]),
            .high_water (bus.high_water[leaf_slice_lsb(NUM_IN_PORTS + gi, CNT_BITS) +: CNT_BITS])
        );
    end

endmodule
